rr_packet_arb: RTL and testbench

RR_PACKET_ARB -- requirements
Module: rr_packet_arb

---
 rtl/rr_packet_arb.sv | 141 ++++++++++++++
 tb/tb_rr_packet_arb.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rr_packet_arb.sv
// Packet-locked round-robin arbiter: a grant is held until the tail flit is accepted.
// Optional hold timeout with forced release is enabled by defining RR_ARB_TIMEOUT_EN.
module rr_packet_arb #(
    parameter int unsigned IN_N     = 5,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [IN_N-1:0]          req_i,
    input  logic                     ack_i,
    input  logic                     last_i,
    output logic                     grant_valid_o,
    output logic [IN_N-1:0]          grant_oh_o,
    output logic [$clog2(IN_N)-1:0]  grant_o,
    output logic                     timeout_o
);

    localparam int unsigned GNT_W = $clog2(IN_N);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [GNT_W-1:0] ptr_q, ptr_d;
    logic [GNT_W-1:0] grant_q, grant_d;
    logic [IN_N-1:0]  grant_oh_q, grant_oh_d;

    logic             force_c;
    logic             release_c;
    logic [GNT_W-1:0] ptr_after_c;
    logic [GNT_W-1:0] base_c;
    logic             pick_vld_c;
    logic [GNT_W-1:0] pick_idx_c;

    // Pointer that a release would install: one past the current grant, wrapping at IN_N.
    assign ptr_after_c = (grant_q == GNT_W'(IN_N - 1)) ? '0 : grant_q + GNT_W'(1);
    assign release_c   = (state_q == BUSY) && ((ack_i && last_i) || force_c);
    assign base_c      = (state_q == BUSY) ? ptr_after_c : ptr_q;

    // Search req_i upward from base_c; iterating downward leaves the nearest hit.
    always_comb begin : arb_search
        int unsigned idx;
        idx        = 0;
        pick_vld_c = 1'b0;
        pick_idx_c = '0;
        for (int i = int'(IN_N) - 1; i >= 0; i--) begin
            idx = 32'(base_c) + 32'(i);
            if (idx >= IN_N) begin
                idx = idx - IN_N;
            end
            if (req_i[idx[GNT_W-1:0]]) begin
                pick_vld_c = 1'b1;
                pick_idx_c = GNT_W'(idx);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            grant_oh_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        case (state_q)
            IDLE: begin
                if (pick_vld_c) begin
                    state_d    = BUSY;
                    grant_d    = pick_idx_c;
                    grant_oh_d = IN_N'(1) << pick_idx_c;
                end
            end
            BUSY: begin
                if (release_c) begin
                    ptr_d = ptr_after_c;
                    if (pick_vld_c) begin
                        grant_d    = pick_idx_c;
                        grant_oh_d = IN_N'(1) << pick_idx_c;
                    end else begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        grant_oh_d = '0;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                grant_d    = '0;
                grant_oh_d = '0;
            end
        endcase
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD);

    logic [CNT_W-1:0] hold_cnt_q;
    logic             timeout_q;
    logic             timeout_d;

    // hold_cnt_q holds completed BUSY cycles; release fires in the (MAX_HOLD-1)th one.
    assign force_c   = (hold_cnt_q == CNT_W'(MAX_HOLD - 2));
    assign timeout_d = (state_q == BUSY) && force_c && !(ack_i && last_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
            if ((state_q != BUSY) || release_c) begin
                hold_cnt_q <= '0;
            end else begin
                hold_cnt_q <= hold_cnt_q + CNT_W'(1);
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign force_c   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign grant_valid_o = (state_q == BUSY);
    assign grant_o       = grant_q;
    assign grant_oh_o    = grant_oh_q;

endmodule

// File: tb/tb_rr_packet_arb.sv
// Directed bench for rr_packet_arb (IN_N=5, MAX_HOLD=16); covers both RR_ARB_TIMEOUT_EN builds.
module tb_rr_packet_arb;

    localparam int unsigned IN_N     = 5;
    localparam int unsigned MAX_HOLD = 16;
    localparam int unsigned GNT_W    = $clog2(IN_N);

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [IN_N-1:0]  req_i;
    logic             ack_i;
    logic             last_i;
    logic             grant_valid_o;
    logic [IN_N-1:0]  grant_oh_o;
    logic [GNT_W-1:0] grant_o;
    logic             timeout_o;

    int checks = 0;
    int errors = 0;

    rr_packet_arb #(.IN_N(IN_N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .ack_i         (ack_i),
        .last_i        (last_i),
        .grant_valid_o (grant_valid_o),
        .grant_oh_o    (grant_oh_o),
        .grant_o       (grant_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Idle outputs are all zero; a valid grant g has one-hot 1<<g.
    task automatic check_grant(input string tag, input logic vld, input int g, input logic to);
        logic [IN_N-1:0] oh;
        oh = vld ? IN_N'(1) << g : '0;
        check({tag, ".valid"},   32'(grant_valid_o), 32'(vld));
        check({tag, ".grant"},   32'(grant_o),       vld ? 32'(g) : 32'd0);
        check({tag, ".oh"},      32'(grant_oh_o),    32'(oh));
        check({tag, ".timeout"}, 32'(timeout_o),     32'(to));
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int seq[6];
        seq = '{0, 1, 2, 3, 4, 0};
        rst_i  = 1'b1;
        req_i  = '0;
        ack_i  = 1'b0;
        last_i = 1'b0;
        #3;
        check_grant("reset", 1'b0, 0, 1'b0);
        #3 rst_i = 1'b0;

        // Single requester, one-cycle latency.
        req_i = 5'b00100;
        step();
        check_grant("single_req", 1'b1, 2, 1'b0);

        // Async reset clears everything without a clock edge.
        #2 rst_i = 1'b1;
        #1 check_grant("async_rst", 1'b0, 0, 1'b0);
        #1 rst_i = 1'b0;
        req_i = '0;
        step();
        check_grant("idle_no_req", 1'b0, 0, 1'b0);

        // All request, release every cycle: strict rotation, no bubbles.
        req_i = 5'b11111;
        step();
        check_grant("rot0", 1'b1, seq[0], 1'b0);
        ack_i  = 1'b1;
        last_i = 1'b1;
        for (int i = 1; i < 6; i++) begin
            step();
            check_grant($sformatf("rot%0d", i), 1'b1, seq[i], 1'b0);
        end

        // Grant on 1 (ptr 1), then drop request and ack body flits: grant holds.
        req_i = 5'b00010;
        step();
        check_grant("get1", 1'b1, 1, 1'b0);
        req_i  = '0;
        last_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_grant($sformatf("body%0d", i), 1'b1, 1, 1'b0);
        end
        ack_i  = 1'b0;
        last_i = 1'b1;
        step();
        check_grant("last_no_ack", 1'b1, 1, 1'b0);

        // Tail accepted: search from 2 wraps to input 0.
        ack_i = 1'b1;
        req_i = 5'b00001;
        step();
        check_grant("wrap0", 1'b1, 0, 1'b0);
        req_i = '0;
        step();
        check_grant("rel_to_idle", 1'b0, 0, 1'b0);

        // Ack/last while idle are ignored; ptr is 1, so 5'b10001 picks 4.
        step();
        check_grant("idle_ack", 1'b0, 0, 1'b0);
        ack_i  = 1'b0;
        last_i = 1'b0;
        req_i  = 5'b10001;
        step();
        check_grant("ptr1_pick4", 1'b1, 4, 1'b0);

        // Releasing input regains the grant only when alone.
        ack_i  = 1'b1;
        last_i = 1'b1;
        req_i  = 5'b10000;
        step();
        check_grant("alone_regrant", 1'b1, 4, 1'b0);
        req_i = 5'b10001;
        step();
        check_grant("other_wins", 1'b1, 0, 1'b0);

        // Reach grant 3 with ptr 3, then reset mid-packet: ptr must return to 0.
        req_i = 5'b00100;
        step();
        check_grant("get2", 1'b1, 2, 1'b0);
        req_i = 5'b01000;
        step();
        check_grant("get3", 1'b1, 3, 1'b0);
        ack_i  = 1'b0;
        last_i = 1'b0;
        #2 rst_i = 1'b1;
        #1 check_grant("mid_rst", 1'b0, 0, 1'b0);
        #1 rst_i = 1'b0;
        req_i = 5'b01001;
        step();
        check_grant("post_rst_ptr0", 1'b1, 0, 1'b0);

        // Grant 4 (ptr 1 after release of 0), then never ack.
        ack_i  = 1'b1;
        last_i = 1'b1;
        req_i  = 5'b10000;
        step();
        check_grant("get4", 1'b1, 4, 1'b0);
        ack_i  = 1'b0;
        last_i = 1'b0;
        req_i  = 5'b10011;
`ifdef RR_ARB_TIMEOUT_EN
        for (int i = 2; i <= 15; i++) begin
            step();
            check_grant($sformatf("hold%0d", i), 1'b1, 4, 1'b0);
        end
        step();
        check_grant("forced_rel", 1'b1, 0, 1'b1);
        step();
        check_grant("pulse_end", 1'b1, 0, 1'b0);
`else
        for (int i = 2; i <= 24; i++) begin
            step();
            check_grant($sformatf("hold%0d", i), 1'b1, 4, 1'b0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
